// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: a single-outstanding-request fetch FSM filling a
// circular FIFO of {pc, inst} entries that feeds the IF/ID pipeline register.
module fetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    input  logic        out_ready
);

    localparam int              PTR_W   = $clog2(DEPTH);
    localparam int              CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [31:0]     PC_STEP = 32'd4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      addr_q, addr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [31:0] buf_pc_q   [DEPTH];
    logic [31:0] buf_inst_q [DEPTH];

    logic             pop;
    logic             push;
    logic [CNT_W-1:0] count_after_pop;
    logic [CNT_W-1:0] count_after_push;
    logic [31:0]      redirect_target;
    logic [31:0]      addr_next;

    assign out_valid        = (count_q != '0);
    assign out_pc           = out_valid ? buf_pc_q[rd_ptr_q]   : '0;
    assign out_inst         = out_valid ? buf_inst_q[rd_ptr_q] : '0;
    assign imem_req         = (state_q == ST_WAIT) || (state_q == ST_DROP);
    assign imem_addr        = addr_q;

    assign pop              = out_valid & out_ready & ~redirect;
    assign count_after_pop  = count_q - (pop ? CNT_ONE : '0);
    assign count_after_push = count_after_pop + CNT_ONE;
    assign redirect_target  = redirect_pc & 32'hFFFF_FFFC;
    assign addr_next        = addr_q + PC_STEP;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        push       = 1'b0;

        if (redirect) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            fetch_pc_d = redirect_target;
            // An in-flight request must still be retired by its ack before a new one issues.
            case (state_q)
                ST_WAIT: state_d = imem_ack ? ST_IDLE : ST_DROP;
                ST_DROP: state_d = imem_ack ? ST_IDLE : ST_DROP;
                default: state_d = ST_IDLE;
            endcase
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                count_d  = count_after_pop;
            end
            case (state_q)
                ST_IDLE: begin
                    if (count_after_pop < DEPTH_C) begin
                        state_d = ST_WAIT;
                        addr_d  = fetch_pc_q;
                    end
                end
                ST_WAIT: begin
                    if (imem_ack) begin
                        push       = 1'b1;
                        wr_ptr_d   = wr_ptr_q + PTR_ONE;
                        count_d    = count_after_push;
                        fetch_pc_d = addr_next;
                        // Chain straight into the next request to sustain one word per cycle.
                        if (count_after_push < DEPTH_C) begin
                            addr_d = addr_next;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_DROP: begin
                    if (imem_ack) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Entry storage carries no reset; the outputs are masked whenever count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc_q[wr_ptr_q]   <= addr_q;
            buf_inst_q[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer with a zero-wait or manually acked memory
// whose returned word is the bitwise inverse of the requested address.
module tb_fetch_buffer;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready;

    logic auto_ack;
    logic man_ack;
    int   checks;
    int   errors;

    assign imem_ack   = auto_ack ? imem_req : man_ack;
    assign imem_rdata = ~imem_addr;

    fetch_buffer #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_inst    (out_inst),
        .out_ready   (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset(input logic ready, input logic auto);
        @(negedge clk);
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        out_ready   = ready;
        auto_ack    = auto;
        man_ack     = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc;
        apply_reset(1'b1, 1'b1);
        rst = 1'b1;
        step();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 00000000", imem_addr); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 00000000", out_pc); end
        checks++; if (out_inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h expected 00000000", out_inst); end
        rst = 1'b0;
        step();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b expected 1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL first_addr: got %h expected 00000000", imem_addr); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL first_valid_early: got %b expected 0", out_valid); end
        for (int i = 0; i < 4; i++) begin
            exp_pc = 32'(i * 4);
            step();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, out_valid); end
            checks++; if (out_pc !== exp_pc) begin errors++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, out_pc, exp_pc); end
            checks++; if (out_inst !== ~exp_pc) begin errors++; $display("FAIL stream_inst[%0d]: got %h expected %h", i, out_inst, ~exp_pc); end
        end
    endtask

    task automatic test_fill_stall();
        logic [31:0] exp_pc;
        apply_reset(1'b0, 1'b1);
        repeat (4) step();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL fill_req_3: got %b expected 1", imem_req); end
        step();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL fill_req_full: got %b expected 0", imem_req); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL fill_head: got %h expected 00000000", out_pc); end
        repeat (3) step();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL fill_idle_hold: got %b expected 0", imem_req); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fill_valid_hold: got %b expected 1", out_valid); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL fill_head_hold: got %h expected 00000000", out_pc); end
        out_ready = 1'b1;
        step();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL resume_req: got %b expected 1", imem_req); end
        checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL resume_addr: got %h expected 00000010", imem_addr); end
        for (int i = 1; i <= 4; i++) begin
            exp_pc = 32'(i * 4);
            if (i > 1) step();
            checks++; if (out_pc !== exp_pc) begin errors++; $display("FAIL drain_pc[%0d]: got %h expected %h", i, out_pc, exp_pc); end
        end
    endtask

    task automatic test_redirect_flush();
        apply_reset(1'b0, 1'b1);
        repeat (4) step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_valid: got %b expected 1", out_valid); end
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        step();
        redirect = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL flush_req: got %b expected 0", imem_req); end
        step();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL flush_new_req: got %b expected 1", imem_req); end
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL flush_new_addr: got %h expected 00000100", imem_addr); end
        step();
        checks++; if (out_pc !== 32'h100) begin errors++; $display("FAIL flush_new_pc: got %h expected 00000100", out_pc); end
        checks++; if (out_inst !== 32'hFFFF_FEFF) begin errors++; $display("FAIL flush_new_inst: got %h expected fffffeff", out_inst); end
    endtask

    task automatic test_drop();
        apply_reset(1'b1, 1'b0);
        step();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL drop_req0: got %b expected 1", imem_req); end
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        step();
        redirect = 1'b0;
        checks++; if (dut.state_q !== 2'd2) begin errors++; $display("FAIL drop_state: got %0d expected 2", dut.state_q); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL drop_addr_stable: got %h expected 00000000", imem_addr); end
        step();
        step();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL drop_req_hold: got %b expected 1", imem_req); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drop_valid_wait: got %b expected 0", out_valid); end
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL drop_done_req: got %b expected 0", imem_req); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drop_late_data: got %b expected 0", out_valid); end
        auto_ack = 1'b1;
        step();
        checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL drop_target_addr: got %h expected 00000200", imem_addr); end
        step();
        checks++; if (out_pc !== 32'h200) begin errors++; $display("FAIL drop_target_pc: got %h expected 00000200", out_pc); end
        step();
        checks++; if (out_pc !== 32'h204) begin errors++; $display("FAIL drop_next_pc: got %h expected 00000204", out_pc); end
    endtask

    task automatic test_wrap();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        step();
        redirect = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wrap_flush: got %b expected 0", out_valid); end
        step();
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr: got %h expected fffffffc", imem_addr); end
        step();
        checks++; if (out_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc0: got %h expected fffffffc", out_pc); end
        checks++; if (out_inst !== 32'h0000_0003) begin errors++; $display("FAIL wrap_inst0: got %h expected 00000003", out_inst); end
        step();
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL wrap_pc1: got %h expected 00000000", out_pc); end
        step();
        checks++; if (out_pc !== 32'h4) begin errors++; $display("FAIL wrap_pc2: got %h expected 00000004", out_pc); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_pc;
        out_ready = 1'b0;
        step();
        checks++; if (out_pc !== 32'h4) begin errors++; $display("FAIL stall_hold_pc: got %h expected 00000004", out_pc); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_hold_valid: got %b expected 1", out_valid); end
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            exp_pc = 32'(4 + 4 * i);
            step();
            checks++; if (out_pc !== exp_pc) begin errors++; $display("FAIL b2b_pc[%0d]: got %h expected %h", i, out_pc, exp_pc); end
        end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL b2b_req: got %b expected 1", imem_req); end
    endtask

    task automatic test_rst_mid_wait();
        apply_reset(1'b1, 1'b0);
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        step();
        redirect = 1'b0;
        man_ack  = 1'b1;
        step();
        man_ack = 1'b0;
        step();
        checks++; if (imem_addr !== 32'h300) begin errors++; $display("FAIL mid_wait_addr: got %h expected 00000300", imem_addr); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL async_rst_req: got %b expected 0", imem_req); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_rst_valid: got %b expected 0", out_valid); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL async_rst_addr: got %h expected 00000000", imem_addr); end
        man_ack = 1'b1;
        step();
        rst = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL late_ack_ignored: got %b expected 0", out_valid); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL post_rst_addr: got %h expected 00000000", imem_addr); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL post_rst_req: got %b expected 1", imem_req); end
        man_ack  = 1'b0;
        auto_ack = 1'b1;
        step();
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL post_rst_pc: got %h expected 00000000", out_pc); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL post_rst_valid: got %b expected 1", out_valid); end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        out_ready   = 1'b1;
        auto_ack    = 1'b1;
        man_ack     = 1'b0;
        test_reset();
        test_fill_stall();
        test_redirect_flush();
        test_drop();
        test_wrap();
        test_back_to_back();
        test_rst_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 The block SHALL have a parameter DEPTH, default 4, giving the number of instruction-buffer entries (power of two, range 2 to 16).
REQ-002 The block SHALL have a parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-003 Clocking SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 imem_req  output  1  a fetch request is outstanding.
REQ-007 imem_addr  output  32  the fetch address, word-aligned.
REQ-008 imem_ack  input  1  the instruction memory returns imem_rdata this cycle; it is ignored while imem_req=0.
REQ-009 imem_rdata  input  32  the fetched instruction word.
REQ-010 redirect  input  1  a taken branch, jump or trap from downstream; the buffer is flushed.
REQ-011 redirect_pc  input  32  the new fetch target.
REQ-012 out_valid  output  1  the head entry is valid.
REQ-013 out_pc  output  32  the PC of the head entry; it feeds the IF/ID pipeline register.
REQ-014 out_inst  output  32  the instruction of the head entry.
REQ-015 out_ready  input  1  the IF/ID stage accepts the head entry; this input is held low for a stall.

Function
REQ-016 Storage: the block SHALL hold a circular FIFO of DEPTH entries {pc, inst}, with read pointer, write pointer and count registers.
REQ-017 Outputs: out_valid SHALL equal (count != 0), and out_pc/out_inst SHALL be driven from the head entry.
REQ-018 Pop: the head entry SHALL be popped on a rising edge where out_valid & out_ready & !redirect.
REQ-019 Fetch FSM states SHALL be IDLE, WAIT and DROP, and imem_req SHALL be 1 exactly in WAIT and DROP.
REQ-020 IDLE -> WAIT SHALL occur when count_after_pop < DEPTH and !redirect, with imem_addr <= fetch_pc.
REQ-021 WAIT with imem_ack and no redirect SHALL push {imem_addr, imem_rdata} and set fetch_pc <= imem_addr + 4.
REQ-022 After the REQ-021 push, the FSM SHALL stay in WAIT with the next address if space remains after this cycle's push/pop, and SHALL otherwise go to IDLE.
REQ-023 Only one request SHALL be outstanding at a time, and imem_addr SHALL be stable while imem_req=1 until imem_ack.
REQ-024 Redirect handling: redirect SHALL clear count and both pointers and set fetch_pc <= {redirect_pc[31:2], 2'b00}.
REQ-025 Redirect from IDLE SHALL go to IDLE, and the new fetch SHALL issue on the next cycle.
REQ-026 Redirect in WAIT without imem_ack SHALL go to DROP.
REQ-027 Redirect in WAIT with imem_ack SHALL discard the returned data and go to IDLE.
REQ-028 DROP: on imem_ack the returned data SHALL be discarded and the FSM SHALL go to IDLE; the redirect target issues from IDLE.
REQ-029 A redirect while in DROP SHALL update fetch_pc only and stay in DROP.
REQ-030 Priority SHALL be redirect > push/pop, and in a redirect cycle no entry SHALL be popped or pushed.
REQ-031 A simultaneous push and pop SHALL leave count unchanged, and a push when full SHALL never occur by construction.
REQ-032 Arithmetic: fetch_pc + 4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), and pointers SHALL wrap modulo DEPTH.
REQ-033 Latency: with a zero-wait memory (imem_ack in the first WAIT cycle), the first entry SHALL appear at out_valid 2 cycles after reset release.
REQ-034 Throughput: with a zero-wait memory and out_ready held high, the sustained rate SHALL be 1 instruction per cycle.

Reset
REQ-035 While rst=1: state=IDLE, count=0, pointers=0, fetch_pc=RESET_PC, imem_req=0, out_valid=0.
REQ-036 While rst=1, imem_addr SHALL be RESET_PC, and out_pc/out_inst SHALL be 0.
REQ-037 Assertion of rst SHALL take effect immediately, mid-request, and a late imem_ack SHALL be ignored because imem_req=0.

Verification
REQ-038 Reset release with zero-wait memory and out_ready=1: the bench SHALL check out_pc = 0, 4, 8, 12 on consecutive cycles, each paired with the matching imem_rdata.
REQ-039 out_ready=0 with DEPTH=4: the bench SHALL check that exactly 4 entries fill, after which imem_req=0 and IDLE holds; releasing out_ready SHALL drain PCs 0, 4, 8, 12 and fetching SHALL resume at 16.
REQ-040 Redirect to 32'h0000_0103 while 3 entries are buffered: the bench SHALL check out_valid=0 the next cycle, and that the next fetch address is 32'h0000_0100.
REQ-041 Redirect in WAIT with ack delayed 3 cycles: the bench SHALL check that the FSM enters DROP, the late data is never output, and the next request address is the redirect target.
REQ-042 Wrap: redirect to 32'hFFFF_FFFC; the bench SHALL check out_pc sequence FFFF_FFFC, 0000_0000.
REQ-043 rst asserted mid-WAIT: the bench SHALL check that imem_req drops asynchronously, out_valid=0, and after release the first request is to RESET_PC.
